am_lock_rx: RTL and testbench

// Per-PCS-lane receive alignment-marker (AM) lock and removal; inverse of TX marker insertion.

---
 rtl/am_lock_rx.sv | 272 +++++++++++++++++++++++++++
 tb/tb_am_lock_rx.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/am_lock_rx.sv
// ---------------------------------------------------------------------------
// am_lock_rx
// Receive-side alignment-marker lock and removal for one 66b PCS lane.
// This block undoes TX marker insertion. It sits after block lock and ahead of
// lane deskew/reorder. It does four jobs:
//   - finds the periodic alignment marker and confirms it with a second one,
//   - identifies the physical lane (0..3) that the marker belongs to,
//   - removes marker slots from the valid stream while locked,
//   - drops lock after AM_BAD_N consecutive bad markers.
//
// Optional feature, enabled by defining the macro AM_LOCK_RX_BIP_EN:
//   A BIP8 accumulator is compared with BIP3 on each good locked marker.
//   bip_err_o pulses when the two differ.
//   With the macro undefined, bip_err_o is tied to 0.
//
// Ports
//   clk          clock
//   reset        asynchronous, active-high reset
//   valid_i      input block valid; low = bubble
//   head_i       sync header; 2'b01 = control block
//   data_i       payload; [23:0] M0..M2, [31:24] BIP3,
//                [55:32] ~M0..~M2, [63:56] BIP7
//   valid_o      output valid; low on bubbles and on removed marker slots
//   head_o       registered head_i (held across bubbles)
//   data_o       registered data_i (held across bubbles)
//   marker_v_o   output slot is the expected marker position (locked only)
//   am_lock_o    alignment marker lock
//   lane_id_o    lane ID of the locked marker; meaningful when am_lock_o=1
//   bip_err_o    one-cycle pulse: BIP3 mismatch on a good locked marker
//   state_dbg_o  current FSM state (0 FIND, 1 CONFIRM, 2 LOCKED)
//
// Handshake: there is no backpressure. A block is consumed on every clock
// edge where valid_i=1. The block appears on the outputs one cycle later,
// with valid_o=1 unless it is a removed marker slot.
// ---------------------------------------------------------------------------
`default_nettype none

module am_lock_rx #(
  parameter int HEAD_W    = 2,
  parameter int DATA_W    = 64,
  parameter int AM_PERIOD = 16384,
  parameter int AM_BAD_N  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic [HEAD_W-1:0] head_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [HEAD_W-1:0] head_o,
  output logic [DATA_W-1:0] data_o,
  output logic              marker_v_o,
  output logic              am_lock_o,
  output logic [1:0]        lane_id_o,
  output logic              bip_err_o,
  output logic [1:0]        state_dbg_o
);

  localparam int CNT_W = (AM_PERIOD > 1) ? $clog2(AM_PERIOD) : 1;
  localparam int BAD_W = $clog2(AM_BAD_N + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AM_PERIOD - 1);
  localparam logic [BAD_W-1:0] BAD_LAST = BAD_W'(AM_BAD_N - 1);

  // {M2,M1,M0} per lane, indexed by lane number.
  localparam logic [3:0][23:0] AM_TBL = {24'h3D79A2, 24'h9B65C5,
                                         24'hE6C4F0, 24'h477690};

  typedef enum logic [1:0] {
    ST_FIND    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BAD_W-1:0]   bad_q, bad_d;
  logic [1:0]         id_q, id_d;
  logic [1:0]         lane_id_q, lane_id_d;
  logic               valid_q, marker_v_q, am_lock_q;
  logic [HEAD_W-1:0]  head_q;
  logic [DATA_W-1:0]  data_q;

  // -------------------------------------------------------------------------
  // Marker match against all four lanes.
  // BIP3/BIP7 bytes take no part in the match.
  // -------------------------------------------------------------------------
  logic       is_ctrl;
  logic       inv_ok;
  logic [3:0] match;
  logic       any_match;
  logic [1:0] match_id;

  always_comb begin
    is_ctrl   = (head_i == HEAD_W'(1));
    inv_ok    = (data_i[55:32] == ~data_i[23:0]);
    match     = '0;
    any_match = 1'b0;
    match_id  = '0;
    for (int l = 0; l < 4; l++) begin
      match[l] = is_ctrl && inv_ok && (data_i[23:0] == AM_TBL[l]);
      if (match[l]) begin
        any_match = 1'b1;
        match_id  = 2'(l);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Slot counter and lock FSM next-state logic.
  // cnt_q is the position of the current block within the marker period.
  // A marker is due when cnt_q reaches AM_PERIOD-1; the count then wraps.
  // Bubbles freeze everything.
  // -------------------------------------------------------------------------
  logic am_slot;
  logic slot_rm;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bad_d     = bad_q;
    id_d      = id_q;
    lane_id_d = lane_id_q;
    am_slot   = (cnt_q == CNT_LAST);
    slot_rm   = 1'b0;

    if (valid_i) begin
      cnt_d = am_slot ? '0 : cnt_q + CNT_W'(1);
      case (state_q)
        ST_FIND: begin
          // The counter is parked at 0 while searching. A hit restarts the
          // period from this block.
          cnt_d = '0;
          if (any_match) begin
            id_d    = match_id;
            state_d = ST_CONFIRM;
          end
        end
        ST_CONFIRM: begin
          if (am_slot) begin
            if (match[id_q]) begin
              state_d   = ST_LOCKED;
              lane_id_d = id_q;
              bad_d     = '0;
            end else begin
              // This block is not retried as a first marker. FIND starts
              // with the next valid block.
              state_d = ST_FIND;
            end
          end
        end
        ST_LOCKED: begin
          if (am_slot) begin
            // The slot is removed whether the marker is good or bad.
            slot_rm = 1'b1;
            if (match[id_q]) begin
              bad_d = '0;
            end else if (bad_q == BAD_LAST) begin
              state_d = ST_FIND;
              bad_d   = '0;
            end else begin
              bad_d = bad_q + BAD_W'(1);
            end
          end
        end
        default: state_d = ST_FIND;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State and registered outputs.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_FIND;
      cnt_q      <= '0;
      bad_q      <= '0;
      id_q       <= '0;
      lane_id_q  <= '0;
      valid_q    <= 1'b0;
      marker_v_q <= 1'b0;
      am_lock_q  <= 1'b0;
      head_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bad_q      <= bad_d;
      id_q       <= id_d;
      lane_id_q  <= lane_id_d;
      valid_q    <= valid_i && !slot_rm;
      marker_v_q <= slot_rm;
      am_lock_q  <= (state_d == ST_LOCKED);
      // Head and data hold their last value across a bubble.
      if (valid_i) begin
        head_q <= head_i;
        data_q <= data_i;
      end
    end
  end

  assign valid_o     = valid_q;
  assign head_o      = head_q;
  assign data_o      = data_q;
  assign marker_v_o  = marker_v_q;
  assign am_lock_o   = am_lock_q;
  assign lane_id_o   = lane_id_q;
  assign state_dbg_o = state_q;

`ifdef AM_LOCK_RX_BIP_EN
  // -------------------------------------------------------------------------
  // BIP8 checking.
  // The accumulator covers every valid block from the previous marker slot
  // (included) up to the current one (excluded).
  // After the compare, it restarts from the current marker block.
  // arm_q stays low until one locked marker has seeded a full period, so the
  // first marker after lock entry is never checked.
  // -------------------------------------------------------------------------
  logic [7:0] blk_bip;
  logic [7:0] acc_q, acc_d;
  logic       arm_q, arm_d;
  logic       bip_err_q, bip_err_d;

  always_comb begin
    blk_bip = '0;
    for (int k = 0; k < DATA_W / 8; k++) begin
      blk_bip = blk_bip ^ data_i[k*8 +: 8];
    end
    blk_bip[3] = blk_bip[3] ^ head_i[0];
    blk_bip[4] = blk_bip[4] ^ head_i[1];

    acc_d     = acc_q;
    arm_d     = arm_q;
    bip_err_d = 1'b0;
    if (valid_i) begin
      if (state_d == ST_FIND) begin
        acc_d = '0;
        arm_d = 1'b0;
      end else if (am_slot && (state_q != ST_FIND)) begin
        acc_d = blk_bip;
        if ((state_q == ST_LOCKED) && match[id_q]) begin
          bip_err_d = arm_q && (acc_q != data_i[31:24]);
          arm_d     = 1'b1;
        end
      end else begin
        // A FIND hit lands here with acc_q already zero, so the first
        // marker seeds the accumulator.
        acc_d = acc_q ^ blk_bip;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q     <= '0;
      arm_q     <= 1'b0;
      bip_err_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      arm_q     <= arm_d;
      bip_err_q <= bip_err_d;
    end
  end

  assign bip_err_o = bip_err_q;
`else
  assign bip_err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_am_lock_rx.sv
// ---------------------------------------------------------------------------
// tb_am_lock_rx
// Directed bench for am_lock_rx with AM_PERIOD=16 and AM_BAD_N=4.
// Expected values come from hand-written marker constants and a small BIP8
// model that follows the bit/byte definition.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_am_lock_rx;

  localparam int P = 16;

`ifdef AM_LOCK_RX_BIP_EN
  localparam logic BIP_EN = 1'b1;
`else
  localparam logic BIP_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        valid_i;
  logic [1:0]  head_i;
  logic [63:0] data_i;
  logic        valid_o;
  logic [1:0]  head_o;
  logic [63:0] data_o;
  logic        marker_v_o;
  logic        am_lock_o;
  logic [1:0]  lane_id_o;
  logic        bip_err_o;
  logic [1:0]  state_dbg_o;

  am_lock_rx #(
    .HEAD_W   (2),
    .DATA_W   (64),
    .AM_PERIOD(P),
    .AM_BAD_N (4)
  ) dut (
    .clk        (clk),
    .reset      (rst),
    .valid_i    (valid_i),
    .head_i     (head_i),
    .data_i     (data_i),
    .valid_o    (valid_o),
    .head_o     (head_o),
    .data_o     (data_o),
    .marker_v_o (marker_v_o),
    .am_lock_o  (am_lock_o),
    .lane_id_o  (lane_id_o),
    .bip_err_o  (bip_err_o),
    .state_dbg_o(state_dbg_o)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  bacc;
  logic [63:0] last_d;
  logic [63:0] d;
  logic [63:0] m2;

  // -------------------------------------------------------------------------
  // scoreboard helpers
  // -------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic emv,
                         input logic elk, input logic eerr);
    chk($sformatf("%s.valid_o", tag), valid_o, ev);
    chk($sformatf("%s.marker_v_o", tag), marker_v_o, emv);
    chk($sformatf("%s.am_lock_o", tag), am_lock_o, elk);
    chk($sformatf("%s.bip_err_o", tag), bip_err_o, eerr);
  endtask

  task automatic chk_zero(input string tag);
    chk($sformatf("%s.valid_o", tag), valid_o, 0);
    chk($sformatf("%s.head_o", tag), head_o, 0);
    chk($sformatf("%s.data_o", tag), data_o, 0);
    chk($sformatf("%s.marker_v_o", tag), marker_v_o, 0);
    chk($sformatf("%s.am_lock_o", tag), am_lock_o, 0);
    chk($sformatf("%s.lane_id_o", tag), lane_id_o, 0);
    chk($sformatf("%s.bip_err_o", tag), bip_err_o, 0);
    chk($sformatf("%s.state", tag), state_dbg_o, 0);
  endtask

  // -------------------------------------------------------------------------
  // models
  // -------------------------------------------------------------------------
  function automatic logic [7:0] bip8(input logic [1:0] h, input logic [63:0] dd);
    logic [7:0] b;
    for (int j = 0; j < 8; j++) begin
      b[j] = 1'b0;
      for (int k = 0; k < 8; k++) b[j] = b[j] ^ dd[8*k+j];
    end
    b[3] = b[3] ^ h[0];
    b[4] = b[4] ^ h[1];
    return b;
  endfunction

  function automatic logic [63:0] mk(input int lane, input logic [7:0] bip);
    logic [23:0] m;
    case (lane)
      0:       m = 24'h477690;
      1:       m = 24'hE6C4F0;
      2:       m = 24'h9B65C5;
      default: m = 24'h3D79A2;
    endcase
    return {~bip, ~m, bip, m};
  endfunction

  // -------------------------------------------------------------------------
  // driver tasks: inputs change 1ns after the edge, outputs are sampled there
  // -------------------------------------------------------------------------
  task automatic blk(input logic v, input logic [1:0] h, input logic [63:0] dd);
    valid_i = v;
    head_i  = h;
    data_i  = dd;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_n(input int n, input logic elk, input string tag);
    logic [63:0] fd;
    for (int i = 0; i < n; i++) begin
      fd = {$urandom, $urandom};
      blk(1'b1, 2'b10, fd);
      bacc   = bacc ^ bip8(2'b10, fd);
      last_d = fd;
      chk_out(tag, 1'b1, 1'b0, elk, 1'b0);
      chk($sformatf("%s.data_o", tag), data_o, fd);
    end
  endtask

  // Block sent at a marker position: the BIP model restarts from this block.
  task automatic slot(input string tag, input logic [1:0] h, input logic [63:0] sd,
                      input logic ev, input logic emv, input logic elk, input logic eerr);
    blk(1'b1, h, sd);
    bacc   = bip8(h, sd);
    last_d = sd;
    chk_out(tag, ev, emv, elk, eerr);
    chk($sformatf("%s.data_o", tag), data_o, sd);
  endtask

  // -------------------------------------------------------------------------
  // directed sequence
  // -------------------------------------------------------------------------
  initial begin
    rst     = 1'b1;
    valid_i = 1'b0;
    head_i  = 2'b00;
    data_i  = '0;
    bacc    = '0;
    last_d  = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_zero("reset");
    rst = 1'b0;

    // idle traffic never locks
    fill_n(100, 1'b0, "idle");
    chk("idle.state", state_dbg_o, 0);

    // lane 2: first marker -> CONFIRM, second marker -> LOCKED
    slot("find_l2", 2'b01, mk(2, 8'h00), 1'b1, 1'b0, 1'b0, 1'b0);
    chk("find_l2.state", state_dbg_o, 1);
    fill_n(P - 1, 1'b0, "confirm_fill");
    slot("confirm_l2", 2'b01, mk(2, 8'h00), 1'b1, 1'b0, 1'b1, 1'b0);
    chk("confirm_l2.lane_id", lane_id_o, 2);
    chk("confirm_l2.state", state_dbg_o, 2);

    // first locked marker is removed (and not BIP-checked)
    fill_n(P - 1, 1'b1, "lock_fill");
    slot("lock_rm", 2'b01, mk(2, 8'h00), 1'b0, 1'b1, 1'b1, 1'b0);
    chk("lock_rm.lane_id", lane_id_o, 2);

    // three bad markers (a lane-1 match counts as bad), then a good one
    for (int i = 0; i < 3; i++) begin
      fill_n(P - 1, 1'b1, "bad3_fill");
      slot($sformatf("bad3_%0d", i), 2'b01, mk(1, 8'h00), 1'b0, 1'b1, 1'b1, 1'b0);
    end
    fill_n(P - 1, 1'b1, "good_fill");
    m2 = mk(2, bacc);
    slot("good_after3", 2'b01, m2, 1'b0, 1'b1, 1'b1, 1'b0);

    // four bad markers: lock stays through three, drops on the fourth
    for (int i = 0; i < 3; i++) begin
      fill_n(P - 1, 1'b1, "bad4_fill");
      slot($sformatf("bad4_%0d", i), 2'b01, mk(1, 8'h00), 1'b0, 1'b1, 1'b1, 1'b0);
    end
    fill_n(P - 1, 1'b1, "bad4_fill");
    slot("bad4_3", 2'b10, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("bad4_3.state", state_dbg_o, 0);

    // period 17 in CONFIRM: back to FIND, then the late marker restarts CONFIRM
    slot("p17_first", 2'b01, mk(2, 8'h00), 1'b1, 1'b0, 1'b0, 1'b0);
    fill_n(P - 1, 1'b0, "p17_fill");
    slot("p17_slot", 2'b10, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("p17_slot.state", state_dbg_o, 0);
    slot("p17_late", 2'b01, mk(2, 8'h00), 1'b1, 1'b0, 1'b0, 1'b0);
    chk("p17_late.state", state_dbg_o, 1);
    fill_n(P - 1, 1'b0, "relock_fill");
    slot("relock", 2'b01, mk(2, 8'h00), 1'b1, 1'b0, 1'b1, 1'b0);

    // bubbles mid-period: marker still removed at the 16th valid block
    fill_n(3, 1'b1, "bub_fill");
    blk(1'b0, 2'b00, 64'h0);
    chk_out("bubble1", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("bubble1.data_hold", data_o, last_d);
    chk("bubble1.head_hold", head_o, 2'b10);
    fill_n(6, 1'b1, "bub_fill");
    blk(1'b0, 2'b00, 64'h0);
    blk(1'b0, 2'b00, 64'h0);
    chk_out("bubble2", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("bubble2.data_hold", data_o, last_d);
    fill_n(6, 1'b1, "bub_fill");
    m2 = mk(2, bacc);
    slot("bub_rm", 2'b01, m2, 1'b0, 1'b1, 1'b1, 1'b0);

    // BIP: correct BIP3 gives no error
    fill_n(P - 1, 1'b1, "bip_fill");
    m2 = mk(2, bacc);
    slot("bip_ok", 2'b01, m2, 1'b0, 1'b1, 1'b1, 1'b0);

    // one filler has data bit 5 flipped after the model has seen the clean block
    fill_n(7, 1'b1, "bip_fill");
    d    = {$urandom, $urandom};
    bacc = bacc ^ bip8(2'b10, d);
    blk(1'b1, 2'b10, d ^ 64'h20);
    chk_out("bip_flip", 1'b1, 1'b0, 1'b1, 1'b0);
    fill_n(7, 1'b1, "bip_fill");
    m2 = mk(2, bacc);
    slot("bip_bad", 2'b01, m2, 1'b0, 1'b1, 1'b1, BIP_EN);

    // the accumulator restarts after the compare, so the next period is clean
    fill_n(P - 1, 1'b1, "bip_fill");
    m2 = mk(2, bacc);
    slot("bip_clean", 2'b01, m2, 1'b0, 1'b1, 1'b1, 1'b0);

    // asynchronous reset mid-period
    fill_n(5, 1'b1, "pre_rst");
    #3;
    rst     = 1'b1;
    valid_i = 1'b0;
    #1;
    chk_zero("async_rst");
    @(posedge clk); #1;
    chk_zero("rst_edge");
    rst = 1'b0;
    slot("post_rst", 2'b01, mk(2, 8'h00), 1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_rst.state", state_dbg_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
